gray_sobel: RTL and testbench

Streaming 3x3 Sobel edge-magnitude stage that sits directly downstream of the grayscale converter and consumes its 8-bit `gray` / valid stream. It holds two image lines in internal line buffers, keeps a 3x3 sliding window, and emits one 8-bit edge magnitude per accepted pixel. Frame position is tracked internally by row and column counters, because the upstream stream carries no framing.

---
 rtl/gray_sobel_if.sv | 25 ++
 rtl/gray_sobel.sv | 163 ++++++++++++++++
 tb/tb_gray_sobel.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_sobel_if.sv
// Pixel stream bundle between the grayscale converter and the Sobel stage.
// The master drives pixels in; the slave returns edge magnitudes.
interface gray_sobel_if;
    logic       in_valid;
    logic [7:0] gray_in;
    logic       out_valid;
    logic [7:0] edge_out;
    logic       out_eof;

    modport master (
        output in_valid,
        output gray_in,
        input  out_valid,
        input  edge_out,
        input  out_eof
    );

    modport slave (
        input  in_valid,
        input  gray_in,
        output out_valid,
        output edge_out,
        output out_eof
    );
endinterface

// File: rtl/gray_sobel.sv
// Streaming 3x3 Sobel edge magnitude with two line buffers and a sliding window.
// Three register stages: window/counters, gradients, magnitude/saturation.
module gray_sobel #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int SHIFT      = 0
) (
    input  logic         clk,
    input  logic         rst,
    gray_sobel_if.slave  io
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    // ---------------- S0: counters, line buffers, window ----------------
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [2:0][2:0][7:0] win_q, win_d;
    logic v0_q, v0_d;
    logic brd0_q, brd0_d;
    logic eof0_q, eof0_d;

    logic [7:0] lb0 [IMG_WIDTH];
    logic [7:0] lb1 [IMG_WIDTH];
    logic [7:0] lb0_rd, lb1_rd;
    logic       acc;
    logic       last_col, last_row;

    assign acc      = io.in_valid;
    assign lb0_rd   = lb0[col_q];
    assign lb1_rd   = lb1[col_q];
    assign last_col = (col_q == COL_LAST);
    assign last_row = (row_q == ROW_LAST);

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        win_d  = win_q;
        v0_d   = acc;
        brd0_d = brd0_q;
        eof0_d = eof0_q;
        if (acc) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            win_d[0][2] = lb0_rd;
            win_d[1][2] = lb1_rd;
            win_d[2][2] = io.gray_in;
            brd0_d = (row_q >= RW'(2)) && (col_q >= CW'(2));
            eof0_d = last_row && last_col;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            win_q  <= '0;
            v0_q   <= 1'b0;
            brd0_q <= 1'b0;
            eof0_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            win_q  <= win_d;
            v0_q   <= v0_d;
            brd0_q <= brd0_d;
            eof0_q <= eof0_d;
        end
    end

    // Read-before-write: the shift into LB0 sees LB1's previous contents.
    always_ff @(posedge clk) begin
        if (!rst && acc) begin
            lb0[col_q] <= lb1[col_q];
            lb1[col_q] <= io.gray_in;
        end
    end

    // ---------------- S1: gradients ----------------
    logic signed [10:0] gx_q, gx_d;
    logic signed [10:0] gy_q, gy_d;
    logic v1_q, brd1_q, eof1_q;
    logic [10:0] xp, xn, yp, yn;

    always_comb begin
        xp = {3'b0, win_q[0][2]} + {2'b0, win_q[1][2], 1'b0}
           + {3'b0, win_q[2][2]};
        xn = {3'b0, win_q[0][0]} + {2'b0, win_q[1][0], 1'b0}
           + {3'b0, win_q[2][0]};
        yp = {3'b0, win_q[2][0]} + {2'b0, win_q[2][1], 1'b0}
           + {3'b0, win_q[2][2]};
        yn = {3'b0, win_q[0][0]} + {2'b0, win_q[0][1], 1'b0}
           + {3'b0, win_q[0][2]};
        gx_d = $signed(xp - xn);
        gy_d = $signed(yp - yn);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gx_q   <= '0;
            gy_q   <= '0;
            v1_q   <= 1'b0;
            brd1_q <= 1'b0;
            eof1_q <= 1'b0;
        end else begin
            gx_q   <= gx_d;
            gy_q   <= gy_d;
            v1_q   <= v0_q;
            brd1_q <= brd0_q;
            eof1_q <= eof0_q;
        end
    end

    // ---------------- S2: magnitude, shift, saturate ----------------
    logic [10:0] ax, ay, mag, m;
    logic [7:0]  sat;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  edge_q, edge_d;
    logic        eof_q, eof_d;

    always_comb begin
        ax  = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
        ay  = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
        mag = ax + ay;
        m   = mag >> SHIFT;
        sat = (m > 11'd255) ? 8'hff : m[7:0];
        out_valid_d = v1_q;
        edge_d      = edge_q;
        eof_d       = eof_q;
        if (v1_q) begin
            edge_d = brd1_q ? sat : 8'h00;
            eof_d  = eof1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            edge_q      <= '0;
            eof_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            edge_q      <= edge_d;
            eof_q       <= eof_d;
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.edge_out  = edge_q;
    assign io.out_eof   = eof_q;

endmodule

// File: tb/tb_gray_sobel.sv
// Bench for gray_sobel: SHIFT=0 and SHIFT=2 instances on one 8x6 stream,
// checked against a whole-frame Sobel model.
module tb_gray_sobel;

    localparam int W = 8;
    localparam int H = 6;

    typedef struct packed {
        logic       v;
        logic [7:0] e0;
        logic [7:0] e2;
        logic       eof;
    } exp_t;

    logic clk;
    logic rst;
    gray_sobel_if if0 ();
    gray_sobel_if if2 ();

    gray_sobel #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .SHIFT(0)) u0 (
        .clk(clk), .rst(rst), .io(if0.slave)
    );
    gray_sobel #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .SHIFT(2)) u2 (
        .clk(clk), .rst(rst), .io(if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   img [H][W];
    int   mr, mc;
    exp_t q [$];
    int   n_chk, n_fail;
    int   cyc;
    logic [7:0] last0, last2;

    function automatic int sob(int r, int c);
        int p [3][3];
        int gx, gy;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = img[r-2+i][c-2+j];
        gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
        gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
        return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    endfunction

    function automatic int satv(int mag, int s);
        int m;
        m = mag >> s;
        return (m > 255) ? 255 : m;
    endfunction

    task automatic step(input bit v, input int pix, input bit r, output exp_t e);
        exp_t n;
        int   mag;
        rst = r;
        if0.in_valid = v;
        if2.in_valid = v;
        if0.gray_in  = 8'(pix);
        if2.gray_in  = 8'(pix);
        n = '0;
        if (r) begin
            for (int i = 0; i < q.size(); i++) q[i].v = 1'b0;
            mr = 0;
            mc = 0;
        end else if (v) begin
            img[mr][mc] = pix;
            mag   = (mr >= 2 && mc >= 2) ? sob(mr, mc) : 0;
            n.v   = 1'b1;
            n.e0  = 8'(satv(mag, 0));
            n.e2  = 8'(satv(mag, 2));
            n.eof = (mr == H-1 && mc == W-1);
            if (mc == W-1) begin
                mc = 0;
                mr = (mr == H-1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
        q.push_back(n);
        @(posedge clk);
        #1;
        cyc++;
        e = q.pop_front();
        if (r) begin
            last0 = 8'h00;
            last2 = 8'h00;
        end else if (e.v) begin
            last0 = e.e0;
            last2 = e.e2;
        end
    endtask

    task automatic test_reset();
        exp_t e;
        for (int k = 0; k < 5; k++) begin
            step(1'b1 && (k < 2 || 1'b0) ? 1'b1 : 1'b0,
                 int'($urandom_range(0, 255)), k < 2, e);
            n_chk++;
            if (if0.out_valid !== 1'b0 || if2.out_valid !== 1'b0 ||
                if0.edge_out !== 8'h00 || if2.edge_out !== 8'h00 ||
                if0.out_eof !== 1'b0 || if2.out_eof !== 1'b0) begin
                n_fail++;
                $display("FAIL reset k=%0d: v=%b/%b e=%0d/%0d eof=%b/%b, want all 0",
                         k, if0.out_valid, if2.out_valid, if0.edge_out,
                         if2.edge_out, if0.out_eof, if2.out_eof);
            end
        end
    endtask

    task automatic test_flat();
        exp_t e;
        int   nout, neof, first;
        nout  = 0;
        neof  = 0;
        first = -1;
        for (int k = 0; k < W*H + 3; k++) begin
            step(k < W*H, 77, 1'b0, e);
            if (if0.out_valid === 1'b1) begin
                nout++;
                if (first < 0) first = k;
                if (if0.out_eof === 1'b1 && nout == W*H) neof++;
                else if (if0.out_eof === 1'b1) neof += 100;
            end
            n_chk++;
            if (if0.out_valid !== e.v || if2.out_valid !== e.v ||
                (e.v && (if0.edge_out !== 8'h00 || if2.edge_out !== 8'h00 ||
                         if0.out_eof !== e.eof || if2.out_eof !== e.eof))) begin
                n_fail++;
                $display("FAIL flat k=%0d: v=%b e=%0d/%0d eof=%b, want v=%b e=0 eof=%b",
                         k, if0.out_valid, if0.edge_out, if2.edge_out,
                         if0.out_eof, e.v, e.eof);
            end
        end
        n_chk++;
        if (nout != W*H || neof != 1 || first != 2) begin
            n_fail++;
            $display("FAIL flat_count: outs=%0d eof_score=%0d first_k=%0d, want 48 1 2",
                     nout, neof, first);
        end
    endtask

    task automatic test_vstep();
        exp_t e;
        int   hits;
        hits = 0;
        for (int k = 0; k < W*H + 3; k++) begin
            step(k < W*H, ((k % W) >= 4) ? 100 : 0, 1'b0, e);
            if (if0.out_valid === 1'b1 && if0.edge_out === 8'd255) hits++;
            n_chk++;
            if (if0.out_valid !== e.v || if2.out_valid !== e.v ||
                (e.v && (if0.edge_out !== e.e0 || if2.edge_out !== e.e2 ||
                         if0.out_eof !== e.eof || if2.out_eof !== e.eof))) begin
                n_fail++;
                $display("FAIL vstep k=%0d: v=%b e=%0d/%0d eof=%b, want v=%b e=%0d/%0d eof=%b",
                         k, if0.out_valid, if0.edge_out, if2.edge_out,
                         if0.out_eof, e.v, e.e0, e.e2, e.eof);
            end
        end
        n_chk++;
        if (hits != 8) begin
            n_fail++;
            $display("FAIL vstep_hits: got %0d outputs of 255, want 8", hits);
        end
    endtask

    task automatic test_ramp();
        exp_t e;
        for (int k = 0; k < W*H + 3; k++) begin
            step(k < W*H, 10 * (k / W), 1'b0, e);
            n_chk++;
            if (if0.out_valid !== e.v || if2.out_valid !== e.v ||
                (e.v && (if0.edge_out !== e.e0 || if2.edge_out !== e.e2 ||
                         if0.out_eof !== e.eof))) begin
                n_fail++;
                $display("FAIL ramp k=%0d: v=%b e=%0d/%0d eof=%b, want v=%b e=%0d/%0d eof=%b",
                         k, if0.out_valid, if0.edge_out, if2.edge_out,
                         if0.out_eof, e.v, e.e0, e.e2, e.eof);
            end
        end
    endtask

    task automatic test_gapped();
        exp_t e;
        for (int k = 0; k < W*H*3 + 3; k++) begin
            step((k % 3 == 0) && (k < W*H*3),
                 (((k / 3) % W) >= 4) ? 100 : 0, 1'b0, e);
            n_chk++;
            if (if0.out_valid !== e.v || if2.out_valid !== e.v ||
                (e.v && (if0.edge_out !== e.e0 || if2.edge_out !== e.e2 ||
                         if0.out_eof !== e.eof)) ||
                (!e.v && (if0.edge_out !== last0 || if2.edge_out !== last2))) begin
                n_fail++;
                $display("FAIL gapped k=%0d: v=%b e=%0d/%0d, want v=%b e=%0d/%0d hold=%0d/%0d",
                         k, if0.out_valid, if0.edge_out, if2.edge_out,
                         e.v, e.e0, e.e2, last0, last2);
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        int   sent, k;
        bit   v;
        sent = 0;
        k    = 0;
        while ((sent < W*H || k < 3) && cyc < 5000) begin
            v = (sent < W*H) && ($urandom_range(0, 2) != 0);
            if (sent >= W*H) k++;
            step(v, int'($urandom_range(0, 255)), 1'b0, e);
            if (v) sent++;
            n_chk++;
            if (if0.out_valid !== e.v || if2.out_valid !== e.v ||
                (e.v && (if0.edge_out !== e.e0 || if2.edge_out !== e.e2 ||
                         if0.out_eof !== e.eof || if2.out_eof !== e.eof)) ||
                (!e.v && (if0.edge_out !== last0 || if2.edge_out !== last2))) begin
                n_fail++;
                $display("FAIL random cyc=%0d: v=%b e=%0d/%0d eof=%b, want v=%b e=%0d/%0d eof=%b",
                         cyc, if0.out_valid, if0.edge_out, if2.edge_out,
                         if0.out_eof, e.v, e.e0, e.e2, e.eof);
            end
        end
        n_chk++;
        if (sent != W*H) begin
            n_fail++;
            $display("FAIL random_budget: sent %0d pixels, want %0d", sent, W*H);
        end
    endtask

    task automatic test_reset_midframe();
        exp_t e;
        int   nout, eof_a, eof_b, neof;
        logic [7:0] first2;
        nout   = 0;
        eof_a  = -1;
        eof_b  = -1;
        neof   = 0;
        first2 = 8'hxx;
        for (int k = 0; k < 20; k++)
            step(1'b1, int'($urandom_range(0, 255)), 1'b0, e);
        step(1'b1, 200, 1'b1, e);
        for (int k = 0; k < 2*W*H + 3; k++) begin
            step(k < 2*W*H, 10 * ((k / W) % H), 1'b0, e);
            if (if0.out_valid === 1'b1) begin
                nout++;
                if (nout == W*H + 1) first2 = if0.edge_out;
                if (if0.out_eof === 1'b1) begin
                    neof++;
                    if (eof_a < 0) eof_a = nout;
                    else eof_b = nout;
                end
            end
            n_chk++;
            if (if0.out_valid !== e.v || if2.out_valid !== e.v ||
                (e.v && (if0.edge_out !== e.e0 || if2.edge_out !== e.e2 ||
                         if0.out_eof !== e.eof || if2.out_eof !== e.eof))) begin
                n_fail++;
                $display("FAIL midrst k=%0d: v=%b e=%0d/%0d eof=%b, want v=%b e=%0d/%0d eof=%b",
                         k, if0.out_valid, if0.edge_out, if2.edge_out,
                         if0.out_eof, e.v, e.e0, e.e2, e.eof);
            end
        end
        n_chk++;
        if (nout != 2*W*H || neof != 2 || eof_a != 48 || eof_b != 96) begin
            n_fail++;
            $display("FAIL midrst_eof: outs=%0d eofs=%0d at %0d,%0d, want 96 2 at 48,96",
                     nout, neof, eof_a, eof_b);
        end
        n_chk++;
        if (first2 !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_first2: got %0d, want 0", first2);
        end
    endtask

    initial begin
        rst = 1'b1;
        if0.in_valid = 1'b0;
        if2.in_valid = 1'b0;
        if0.gray_in  = 8'h00;
        if2.gray_in  = 8'h00;
        mr = 0;
        mc = 0;
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        last0  = 8'h00;
        last2  = 8'h00;
        q.push_back('0);
        q.push_back('0);
        test_reset();
        test_flat();
        test_vstep();
        test_ramp();
        test_gapped();
        test_random();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
